up_counter_3bit: RTL and testbench

UP_COUNTER_3BIT -- requirements
Module: up_counter_3bit

---
 rtl/up_counter_3bit.sv | 30 +++
 tb/tb_up_counter_3bit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/up_counter_3bit.sv
// Free-running WIDTH-bit up counter with synchronous parallel load.
// The asynchronous active-low reset takes priority over load, and load takes priority over increment.
module up_counter_3bit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q_out
);

  localparam logic [WIDTH-1:0] step = WIDTH'(1);

  logic [WIDTH-1:0] count;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load_en) begin
      count <= data_in;
    end else begin
      count <= count + step;  // wraps modulo 2^WIDTH with no carry out
    end
  end

  assign q_out = count;

endmodule

// File: tb/tb_up_counter_3bit.sv
// Self-checking bench for up_counter_3bit: directed timeline scenarios, then randomized traffic.
// Expected values come from an integer reference model that uses modulo arithmetic.
module tb_up_counter_3bit;

  localparam int WIDTH = 3;
  localparam int MODULUS = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             load_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] q_out;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_val = 0;

  up_counter_3bit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load_en (load_en),
    .data_in (data_in),
    .q_out   (q_out)
  );

  // Rising edges fall at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input int exp);
    logic [WIDTH-1:0] want;
    want = WIDTH'(exp);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: q_out=%b expected=%b at t=%0t", tag, got, want, $time);
    end
  endtask

  // Advance one rising edge, update the reference model from the sampled inputs, and check 1 unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset_n)     exp_val = 0;
    else if (load_en) exp_val = int'(data_in);
    else              exp_val = (exp_val + 1) % MODULUS;
    #1;
    check(tag, q_out, exp_val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    load_en = 1'b0;
    data_in = '0;

    // Reset and count: reset is released at t=12, then the counter shows 1 at t=15 and 2 at t=25.
    #1 check("reset_state", q_out, 0);
    #11 reset_n = 1'b1;
    #1 check("post_release_pre_edge", q_out, 0);
    tick("count_1");
    tick("count_2");

    // Load 5, then increment through the wrap back to 0.
    load_en = 1'b1; data_in = 3'b101;
    tick("load_5");
    load_en = 1'b0; data_in = 3'b000;
    tick("after_load_6");
    tick("after_load_7");
    tick("wrap_0");

    // Second load of 3, then count 4, 5, 6.
    load_en = 1'b1; data_in = 3'b011;
    tick("load_3");
    load_en = 1'b0;
    for (int i = 0; i < 3; i++) tick($sformatf("after_load3_%0d", i));

    // Mid-count reset: q_out must clear immediately, without waiting for a clock edge.
    #3 reset_n = 1'b0;
    #1 check("async_clear", q_out, 0);
    exp_val = 0;
    tick("held_in_reset");
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) tick($sformatf("restart_%0d", i));

    // Held load of 7 over three edges, then one increment wraps to 0.
    load_en = 1'b1; data_in = 3'b111;
    for (int i = 0; i < 3; i++) tick($sformatf("held_load_7_%0d", i));
    load_en = 1'b0;
    tick("held_load_wrap");

    // Reset beats load: q_out stays 0 across the edge.
    tick("pre_rst_load");
    reset_n = 1'b0; load_en = 1'b1; data_in = 3'b110;
    #1 check("rst_load_async", q_out, 0);
    exp_val = 0;
    tick("rst_over_load");
    // Release with load still high: the first edge loads data_in.
    reset_n = 1'b1;
    tick("release_with_load");
    load_en = 1'b0;

    // Randomized traffic, with mid-cycle input glitches and occasional async reset pulses.
    for (int i = 0; i < 300; i++) begin
      logic             ld;
      logic [WIDTH-1:0] d;
      ld = ($urandom_range(0, 3) == 0);
      d  = WIDTH'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        load_en = ~ld; data_in = ~d;
        #2 check("glitch_no_effect", q_out, exp_val);
      end
      if ($urandom_range(0, 24) == 0) begin
        reset_n = 1'b0;
        #1 check("rand_async_clear", q_out, 0);
        exp_val = 0;
        reset_n = 1'b1;
      end
      load_en = ld; data_in = d;
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
